// File: rtl/ah_route_9_19.sv
// ah_route_9_19 -- upstream routing stage for the 9-bit, 18-egress demux.
// Extracts the destination from each head beat, holds it for the body beats,
// and presents every beat with its select through a 2-entry skid buffer.
// Packets with an out-of-range destination are consumed and discarded.
// Optional feature: define AH_ROUTE_DROP_CNT_EN to add the saturating
// 16-bit dropped-packet counter and its drop_cnt port.
module ah_route_9_19 #(
    parameter int DATA_W   = 9,
    parameter int NUM_EGR  = 18,
    parameter int SEL_W    = 5,
    parameter int DEST_LSB = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] ing_data,
    input  logic              ing_last,
    input  logic              ing_valid,
    output logic              ing_ready,
    output logic [DATA_W-1:0] egr_data,
    output logic              egr_last,
    output logic              egr_valid,
    input  logic              egr_ready,
    output logic [SEL_W-1:0]  demux_select
`ifdef AH_ROUTE_DROP_CNT_EN
    ,
    output logic [15:0]       drop_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_HEAD = 2'd0,
        ST_BODY = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              last;
        logic [SEL_W-1:0]  sel;
    } entry_t;

    // One extra bit so the range compare is unsigned and width-matched.
    localparam logic [SEL_W:0] NUM_EGR_W = NUM_EGR[SEL_W:0];

    state_t           state, state_nxt;
    logic [SEL_W-1:0] sel_q;
    entry_t           main_q, skid_q, push_entry;
    logic             main_valid, skid_valid;
    logic             accept, pop, push, drop_head;
    logic [SEL_W-1:0] dest;
    logic             dest_ok;

    assign dest      = ing_data[DEST_LSB +: SEL_W];
    assign dest_ok   = ({1'b0, dest} < NUM_EGR_W);
    assign accept    = ing_valid & ing_ready;
    assign pop       = main_valid & egr_ready;

    assign egr_valid    = main_valid;
    assign egr_data     = main_q.data;
    assign egr_last     = main_q.last;
    assign demux_select = main_q.sel;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_HEAD;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every
            // register samples pre-edge values regardless of block order.
            state <= state_nxt;
        end
    end

    // Next-state: head decides BODY/DROP unless it is also the last beat.
    always_comb begin
        // NOTE: default first so no path leaves state_nxt unassigned (no latch).
        state_nxt = state;
        if (accept) begin
            unique case (state)
                ST_HEAD: if (!ing_last) state_nxt = dest_ok ? ST_BODY : ST_DROP;
                ST_BODY: if (ing_last)  state_nxt = ST_HEAD;
                ST_DROP: if (ing_last)  state_nxt = ST_HEAD;
                default: state_nxt = ST_HEAD;
            endcase
        end
    end

    // Outputs of the FSM: ready, push request and drop event.
    always_comb begin
        ing_ready = (state == ST_DROP) | ~skid_valid;
        push      = 1'b0;
        drop_head = 1'b0;
        unique case (state)
            ST_HEAD: begin
                push      = accept & dest_ok;
                drop_head = accept & ~dest_ok;
            end
            ST_BODY: push = accept;
            default: ;
        endcase
    end

    // The head beat carries its own dest; body beats use the held select.
    always_comb begin
        push_entry.data = ing_data;
        push_entry.last = ing_last;
        push_entry.sel  = (state == ST_HEAD) ? dest : sel_q;
    end

    // Held destination, updated only by an accepted valid head beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q <= '0;
        end else if (accept && state == ST_HEAD && dest_ok) begin
            sel_q <= dest;
        end
    end

    // Skid buffer: main drives egress, skid catches a push while main stalls.
    // A push is only possible with skid empty, since ing_ready is low in
    // HEAD/BODY whenever skid holds a beat and DROP never pushes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the two buffer entries are plain flops, so they are reset
            // too; this gives egr_data/egr_last/demux_select a defined 0.
            main_q     <= '0;
            skid_q     <= '0;
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else begin
            if (pop && skid_valid) begin
                main_q     <= skid_q;
                skid_valid <= 1'b0;
            end else if (push && (!main_valid || pop)) begin
                main_q     <= push_entry;
                main_valid <= 1'b1;
            end else if (push) begin
                skid_q     <= push_entry;
                skid_valid <= 1'b1;
            end else if (pop) begin
                main_valid <= 1'b0;
            end
        end
    end

`ifdef AH_ROUTE_DROP_CNT_EN
    // Saturating count of discarded packets (one per invalid head beat).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= 16'd0;
        end else if (drop_head && drop_cnt != 16'hFFFF) begin
            drop_cnt <= drop_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ah_route_9_19.sv
// Testbench for ah_route_9_19: directed packets, expected egress beats queued
// by the stimulus and compared by an independent egress monitor.
module tb_ah_route_9_19;

    typedef struct packed {
        logic [8:0] data;
        logic       last;
        logic [4:0] sel;
    } beat_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [8:0] ing_data;
    logic       ing_last;
    logic       ing_valid;
    logic       ing_ready;
    logic [8:0] egr_data;
    logic       egr_last;
    logic       egr_valid;
    logic       egr_ready;
    logic [4:0] demux_select;
`ifdef AH_ROUTE_DROP_CNT_EN
    logic [15:0] drop_cnt;
`endif

    int    checks = 0;
    int    errors = 0;
    beat_t exp_q[$];

    always #5 clk = ~clk;

    ah_route_9_19 dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ing_data     (ing_data),
        .ing_last     (ing_last),
        .ing_valid    (ing_valid),
        .ing_ready    (ing_ready),
        .egr_data     (egr_data),
        .egr_last     (egr_last),
        .egr_valid    (egr_valid),
        .egr_ready    (egr_ready),
        .demux_select (demux_select)
`ifdef AH_ROUTE_DROP_CNT_EN
        ,
        .drop_cnt     (drop_cnt)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic expect_beat(input logic [8:0] d, input logic l, input logic [4:0] s);
        beat_t b;
        b.data = d;
        b.last = l;
        b.sel  = s;
        exp_q.push_back(b);
    endtask

    // Offer one beat and hold it until accepted (bounded); returns #1 after the edge.
    task automatic send_beat(input logic [8:0] d, input logic l);
        int  n    = 0;
        bit  done = 0;
        ing_data  = d;
        ing_last  = l;
        ing_valid = 1'b1;
        while (!done) begin
            @(negedge clk);
            if (ing_ready) done = 1;
            n++;
            @(posedge clk);
            #1;
            if (!done && n > 40) begin
                errors++;
                $display("FAIL accept_timeout: beat %0h not accepted after %0d cycles", d, n);
                done = 1;
            end
        end
        ing_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        #1;
        check(name, exp_q.size(), 0);
    endtask

    // Egress monitor: every transferred beat must match the next expected one.
    always @(negedge clk) begin
        if (rst_n && egr_valid && egr_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_egress_beat", {23'd0, egr_data}, 32'hFFFF_FFFF);
            end else begin
                beat_t e;
                e = exp_q.pop_front();
                check("egr_data", {23'd0, egr_data}, {23'd0, e.data});
                check("egr_last", {31'd0, egr_last}, {31'd0, e.last});
                check("demux_select", {27'd0, demux_select}, {27'd0, e.sel});
            end
        end
    end

    initial begin
        int         acc;
        int         idx;
        logic [8:0] bp_data [4];
        logic       bp_last [4];

        rst_n     = 1'b0;
        ing_data  = '0;
        ing_last  = 1'b0;
        ing_valid = 1'b0;
        egr_ready = 1'b1;
        #12;

        // Reset values.
        check("rst_egr_valid", {31'd0, egr_valid}, 0);
        check("rst_egr_data", {23'd0, egr_data}, 0);
        check("rst_egr_last", {31'd0, egr_last}, 0);
        check("rst_demux_select", {27'd0, demux_select}, 0);
        check("rst_ing_ready", {31'd0, ing_ready}, 1);
`ifdef AH_ROUTE_DROP_CNT_EN
        check("rst_drop_cnt", {16'd0, drop_cnt}, 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single packet to dest 5, first beat visible the cycle after acceptance.
        expect_beat(9'h005, 1'b0, 5'd5);
        expect_beat(9'h123, 1'b0, 5'd5);
        expect_beat(9'h0F7, 1'b1, 5'd5);
        send_beat(9'h005, 1'b0);
        check("latency_egr_valid", {31'd0, egr_valid}, 1);
        send_beat(9'h123, 1'b0);
        send_beat(9'h0F7, 1'b1);
        wait_drain("single_pkt_drained");

        // Backpressure: 4 beats to dest 10 offered while egress is stalled.
        bp_data[0] = 9'h00A; bp_last[0] = 1'b0;
        bp_data[1] = 9'h1A1; bp_last[1] = 1'b0;
        bp_data[2] = 9'h1A2; bp_last[2] = 1'b0;
        bp_data[3] = 9'h1A3; bp_last[3] = 1'b1;
        for (int i = 0; i < 4; i++) expect_beat(bp_data[i], bp_last[i], 5'd10);
        egr_ready = 1'b0;
        idx       = 0;
        for (int c = 0; c < 4; c++) begin
            ing_data  = bp_data[idx];
            ing_last  = bp_last[idx];
            ing_valid = 1'b1;
            @(negedge clk);
            if (ing_ready) idx++;
            @(posedge clk);
            #1;
        end
        ing_valid = 1'b0;
        check("bp_accepted", idx, 2);
        check("bp_ing_ready_low", {31'd0, ing_ready}, 0);
        check("bp_egr_valid_held", {31'd0, egr_valid}, 1);
        egr_ready = 1'b1;
        for (int i = 2; i < 4; i++) send_beat(bp_data[i], bp_last[i]);
        wait_drain("bp_drained");

        // Invalid dest 19 (3 beats, dropped) followed by a packet to dest 17.
        send_beat(9'h013, 1'b0);
        @(negedge clk);
        check("drop_ready_1", {31'd0, ing_ready}, 1);
        @(posedge clk);
        #1;
        send_beat(9'h055, 1'b0);
        @(negedge clk);
        check("drop_ready_2", {31'd0, ing_ready}, 1);
        @(posedge clk);
        #1;
        send_beat(9'h066, 1'b1);
        check("drop_no_egress", {31'd0, egr_valid}, 0);
        expect_beat(9'h011, 1'b0, 5'd17);
        expect_beat(9'h0AB, 1'b1, 5'd17);
        send_beat(9'h011, 1'b0);
        send_beat(9'h0AB, 1'b1);
        wait_drain("dest17_drained");
`ifdef AH_ROUTE_DROP_CNT_EN
        check("drop_cnt_one", {16'd0, drop_cnt}, 1);
`endif

        // Select isolation: dest-2 beat stalled while a dest-9 head is accepted.
        expect_beat(9'h002, 1'b1, 5'd2);
        expect_beat(9'h009, 1'b0, 5'd9);
        expect_beat(9'h1FF, 1'b1, 5'd9);
        egr_ready = 1'b0;
        send_beat(9'h002, 1'b1);
        send_beat(9'h009, 1'b0);
        check("iso_stalled_sel", {27'd0, demux_select}, 2);
        egr_ready = 1'b1;
        send_beat(9'h1FF, 1'b1);
        wait_drain("iso_drained");

        // Reset mid-packet with 2 beats buffered in BODY.
        egr_ready = 1'b0;
        send_beat(9'h007, 1'b0);
        send_beat(9'h111, 1'b0);
        check("pre_rst_full", {31'd0, ing_ready}, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_egr_valid", {31'd0, egr_valid}, 0);
        check("midrst_ing_ready", {31'd0, ing_ready}, 1);
        @(negedge clk);
        rst_n     = 1'b1;
        egr_ready = 1'b1;
        @(posedge clk);
        #1;
        expect_beat(9'h004, 1'b1, 5'd4);
        send_beat(9'h004, 1'b1);
        wait_drain("post_rst_drained");

`ifdef AH_ROUTE_DROP_CNT_EN
        // Saturation: 65537 single-beat invalid packets from a zero count.
        check("sat_start_cnt", {16'd0, drop_cnt}, 0);
        ing_data  = 9'h01F;
        ing_last  = 1'b1;
        ing_valid = 1'b1;
        acc       = 0;
        for (int i = 0; i < 65537; i++) begin
            @(negedge clk);
            if (ing_ready) acc++;
            @(posedge clk);
        end
        #1;
        ing_valid = 1'b0;
        check("sat_all_accepted", acc, 65537);
        check("sat_drop_cnt", {16'd0, drop_cnt}, 32'h0000_FFFF);
        check("sat_no_egress", {31'd0, egr_valid}, 0);
`else
        acc = 0;
`endif

        repeat (3) @(posedge clk);
        #1;
        check("final_queue_empty", exp_q.size(), 0);
        check("final_egr_idle", {31'd0, egr_valid}, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
